// File: rtl/sd_spi_cmd_ctrl.sv
// SD-card command controller in SPI mode: drives an Avalon SPI core to run the power-up
// clocking, then sends one 6-byte command per request and returns the R1 byte.
module sd_spi_cmd_ctrl #(
  parameter int DUMMY_BYTES  = 10,
  parameter int RESP_TIMEOUT = 8
) (
  input  logic        CLOCK_50,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [5:0]  cmd_index,
  input  logic [31:0] cmd_arg,
  input  logic [6:0]  cmd_crc,
  output logic        rsp_valid,
  output logic [7:0]  rsp_data,
  output logic        rsp_timeout,
  output logic        init_done,
  output logic        busy,
  output logic        av_chipselect,
  output logic [2:0]  av_address,
  output logic        av_read_n,
  output logic        av_write_n,
  output logic [15:0] av_writedata,
  input  logic [15:0] av_readdata,
  output logic [3:0]  dbg_state,
  output logic [3:0]  dbg_xfer
);

  // Handshake: a command is taken on a cycle where cmd_valid && cmd_ready; cmd_ready is only
  // high in IDLE after init, and rsp_valid is a single-cycle strobe with no back-pressure.

  localparam int CNT_A   = (DUMMY_BYTES > RESP_TIMEOUT) ? DUMMY_BYTES : RESP_TIMEOUT;
  localparam int CNT_MAX = (CNT_A > 6) ? CNT_A : 6;
  localparam int CW      = $clog2(CNT_MAX + 1);

  localparam logic [2:0] REG_RXDATA = 3'd0;
  localparam logic [2:0] REG_TXDATA = 3'd1;
  localparam logic [2:0] REG_STATUS = 3'd2;
  localparam logic [2:0] REG_CTRL   = 3'd3;
  localparam logic [2:0] REG_SSEL   = 3'd5;

  typedef enum logic [3:0] {
    INIT_SS0, INIT_DUMMY, INIT_SS1, IDLE, CMD_SSO,
    CMD_TX, CMD_RESP, CMD_REL, CMD_TRAIL, DONE
  } top_t;

  // Each xfer value names what is on the bus during that cycle.
  typedef enum logic [3:0] {
    X_START, X_REGWR, X_POLL_T, X_CHK_T, X_WR, X_POLL_R, X_CHK_R, X_RD, X_CAP
  } xfer_t;

  top_t          state;
  xfer_t         xs;
  logic [CW-1:0] byte_cnt;
  logic [5:0]    idx_q;
  logic [31:0]   arg_q;
  logic [6:0]    crc_q;
  logic [7:0]    r1_q;
  logic          to_q;
  logic [7:0]    tx_byte;
  logic [15:0]   reg_wdata;
  logic [2:0]    tx_sel;
  logic          unused_rd_hi;

  assign dbg_state    = state;
  assign dbg_xfer     = xs;
  assign tx_sel       = byte_cnt[2:0];
  assign unused_rd_hi = ^av_readdata[15:8];

  always_comb begin
    tx_byte   = 8'hFF;
    reg_wdata = 16'h0000;
    if (state == CMD_TX) begin
      case (tx_sel)
        3'd0:    tx_byte = {2'b01, idx_q};
        3'd1:    tx_byte = arg_q[31:24];
        3'd2:    tx_byte = arg_q[23:16];
        3'd3:    tx_byte = arg_q[15:8];
        3'd4:    tx_byte = arg_q[7:0];
        3'd5:    tx_byte = {crc_q, 1'b1};
        default: tx_byte = 8'hFF;
      endcase
    end
    if (state == INIT_SS1) reg_wdata = 16'h0001;
    else if (state == CMD_SSO) reg_wdata = 16'h0400;
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state         <= INIT_SS0;
      xs            <= X_START;
      byte_cnt      <= '0;
      idx_q         <= '0;
      arg_q         <= '0;
      crc_q         <= '0;
      r1_q          <= 8'hFF;
      to_q          <= 1'b0;
      av_chipselect <= 1'b0;
      av_read_n     <= 1'b1;
      av_write_n    <= 1'b1;
      av_address    <= 3'd0;
      av_writedata  <= 16'h0000;
      cmd_ready     <= 1'b0;
      rsp_valid     <= 1'b0;
      rsp_data      <= 8'hFF;
      rsp_timeout   <= 1'b0;
      init_done     <= 1'b0;
      busy          <= 1'b1;
    end else begin
      av_chipselect <= 1'b0;
      av_read_n     <= 1'b1;
      av_write_n    <= 1'b1;
      rsp_valid     <= 1'b0;
      case (xs)
        X_START: begin
          case (state)
            INIT_SS0, INIT_SS1, CMD_SSO, CMD_REL: begin
              av_chipselect <= 1'b1;
              av_write_n    <= 1'b0;
              av_address    <= (state == CMD_SSO || state == CMD_REL) ? REG_CTRL : REG_SSEL;
              av_writedata  <= reg_wdata;
              xs            <= X_REGWR;
            end
            INIT_DUMMY, CMD_TX, CMD_RESP, CMD_TRAIL: begin
              av_chipselect <= 1'b1;
              av_read_n     <= 1'b0;
              av_address    <= REG_STATUS;
              xs            <= X_POLL_T;
            end
            IDLE: if (cmd_valid && cmd_ready) begin
              idx_q     <= cmd_index;
              arg_q     <= cmd_arg;
              crc_q     <= cmd_crc;
              cmd_ready <= 1'b0;
              busy      <= 1'b1;
              state     <= CMD_SSO;
            end
            DONE: begin
              state     <= IDLE;
              cmd_ready <= 1'b1;
              busy      <= 1'b0;
            end
            default: ;
          endcase
        end
        X_REGWR: begin
          xs       <= X_START;
          byte_cnt <= '0;
          case (state)
            INIT_SS0: state <= INIT_DUMMY;
            INIT_SS1: begin
              state     <= IDLE;
              init_done <= 1'b1;
              cmd_ready <= 1'b1;
              busy      <= 1'b0;
            end
            CMD_SSO:  state <= CMD_TX;
            CMD_REL:  state <= CMD_TRAIL;
            default:  state <= state;
          endcase
        end
        X_POLL_T: xs <= X_CHK_T;
        X_CHK_T: begin
          av_chipselect <= 1'b1;
          if (av_readdata[6]) begin
            av_write_n   <= 1'b0;
            av_address   <= REG_TXDATA;
            av_writedata <= {8'h00, tx_byte};
            xs           <= X_WR;
          end else begin
            av_read_n  <= 1'b0;
            av_address <= REG_STATUS;
            xs         <= X_POLL_T;
          end
        end
        X_WR: begin
          av_chipselect <= 1'b1;
          av_read_n     <= 1'b0;
          av_address    <= REG_STATUS;
          xs            <= X_POLL_R;
        end
        X_POLL_R: xs <= X_CHK_R;
        X_CHK_R: begin
          av_chipselect <= 1'b1;
          av_read_n     <= 1'b0;
          av_address    <= av_readdata[7] ? REG_RXDATA : REG_STATUS;
          xs            <= av_readdata[7] ? X_RD : X_POLL_R;
        end
        X_RD: xs <= X_CAP;
        X_CAP: begin
          xs <= X_START;
          case (state)
            INIT_DUMMY:
              if (byte_cnt == CW'(DUMMY_BYTES - 1)) begin
                state    <= INIT_SS1;
                byte_cnt <= '0;
              end else byte_cnt <= byte_cnt + CW'(1);
            CMD_TX:
              if (byte_cnt == CW'(5)) begin
                state    <= CMD_RESP;
                byte_cnt <= '0;
              end else byte_cnt <= byte_cnt + CW'(1);
            CMD_RESP:
              if (!av_readdata[7]) begin
                r1_q     <= av_readdata[7:0];
                to_q     <= 1'b0;
                state    <= CMD_REL;
                byte_cnt <= '0;
              end else if (byte_cnt == CW'(RESP_TIMEOUT - 1)) begin
                r1_q     <= 8'hFF;
                to_q     <= 1'b1;
                state    <= CMD_REL;
                byte_cnt <= '0;
              end else byte_cnt <= byte_cnt + CW'(1);
            CMD_TRAIL: begin
              state       <= DONE;
              rsp_valid   <= 1'b1;
              rsp_data    <= r1_q;
              rsp_timeout <= to_q;
            end
            default: state <= state;
          endcase
        end
        default: xs <= X_START;
      endcase
    end
  end

endmodule

// File: doc/sd_spi_cmd_ctrl.md
SD_SPI_CMD_CTRL -- requirements
Module: sd_spi_cmd_ctrl

Interface
REQ-001 SHALL have parameter DUMMY_BYTES, default 10, number of 0xFF bytes sent with SS deasserted at init (80 SCLKs, at least 74).
REQ-002 SHALL have parameter RESP_TIMEOUT, default 8, max response-poll bytes (Ncr).
REQ-003 SHALL have one clock and an asynchronous, active-high reset; ports CLOCK_50 in 1 (clock) and reset in 1 (async active-high).
REQ-004 cmd_valid in 1: command request; cmd_ready out 1: controller can accept.
REQ-005 cmd_index in 6: SD command number; cmd_arg in 32: argument; cmd_crc in 7: CRC7.
REQ-006 rsp_valid out 1: one-cycle response strobe; rsp_data out 8: R1 byte; rsp_timeout out 1: no R1 seen (valid with rsp_valid).
REQ-007 init_done out 1: power-up clocking complete; busy out 1: controller not in IDLE.
REQ-008 av_chipselect out 1, av_address out 3, av_read_n out 1, av_write_n out 1, av_writedata out 16, av_readdata in 16: Avalon master to SPI core.

Function
REQ-009 SHALL use SPI core word registers 0 rxdata, 1 txdata, 2 status (bit7 RRDY, bit6 TRDY), 3 control (bit10 SSO), 5 slaveselect.
REQ-010 Avalon write SHALL be one cycle: av_chipselect=1, av_write_n=0, address/data valid that cycle.
REQ-011 Avalon read SHALL be one cycle: av_chipselect=1, av_read_n=0; av_readdata sampled on the next cycle.
REQ-012 When not accessing, outputs SHALL be av_chipselect=0, av_read_n=1, av_write_n=1.
REQ-013 Byte transfer sub-sequence: POLL_T read status -> CHK_T (TRDY=0: back to POLL_T) -> WR txdata={8'h00,byte} -> POLL_R read status -> CHK_R (RRDY=0: back to POLL_R) -> RD rxdata -> CAP latch av_readdata[7:0].
REQ-014 Status polling SHALL be unbounded; no watchdog.
REQ-015 Top states: INIT_SS0, INIT_DUMMY, INIT_SS1, IDLE, CMD_SSO, CMD_TX, CMD_RESP, CMD_REL, CMD_TRAIL, DONE.
REQ-016 INIT_SS0: write slaveselect=0x0000; INIT_DUMMY: send DUMMY_BYTES of 0xFF; INIT_SS1: write slaveselect=0x0001; then init_done=1, go to IDLE.
REQ-017 cmd_ready SHALL be 1 only in IDLE with init_done=1; accept on cmd_valid&&cmd_ready; latch index/arg/crc that cycle; cmd_ready drops next cycle.
REQ-018 CMD_SSO: write control=0x0400 (force SS low).
REQ-019 CMD_TX: send 6 bytes in order {2'b01,cmd_index}, arg[31:24], arg[23:16], arg[15:8], arg[7:0], {cmd_crc,1'b1}.
REQ-020 CMD_RESP: send 0xFF; first received byte with bit7=0 becomes R1; else repeat up to RESP_TIMEOUT bytes.
REQ-021 On timeout: rsp_data=0xFF, rsp_timeout=1.
REQ-022 CMD_REL: write control=0x0000; CMD_TRAIL: send one 0xFF (8 SCLKs with SS high).
REQ-023 DONE: rsp_valid=1 for exactly one cycle with rsp_data/rsp_timeout stable; next state IDLE.
REQ-024 rsp_data and rsp_timeout SHALL hold until the next command's DONE.
REQ-025 Bytes received during CMD_TX and INIT_DUMMY SHALL be discarded.
REQ-026 cmd_valid outside IDLE SHALL be ignored (no queueing).
REQ-027 busy SHALL be 0 only in IDLE.
REQ-028 Byte and timeout counters SHALL be sized for the parameters and SHALL not wrap.

Reset
REQ-029 Reset values: av_chipselect=0, av_read_n=1, av_write_n=1, av_address=0, av_writedata=0, cmd_ready=0, rsp_valid=0, rsp_data=0xFF, rsp_timeout=0, init_done=0, busy=1; state INIT_SS0.
REQ-030 Reset asserted mid-operation SHALL abort immediately, with no further Avalon access, and SHALL rerun the full init on release.

Verification
REQ-031 Release reset, SPI model always TRDY/RRDY -> slaveselect=0 write, exactly 10 txdata writes of 0x00FF, slaveselect=1 write, then init_done=1, cmd_ready=1.
REQ-032 CMD0 (index 0, arg 0, crc 0x4A), card returns 0xFF,0x01 -> txdata 0x40,00,00,00,00,0x95; control 0x0400 before, 0x0000 after; one trailing 0xFF; rsp_valid pulse, rsp_data=0x01, rsp_timeout=0.
REQ-033 Card returns all 0xFF -> exactly 8 response bytes polled, rsp_data=0xFF, rsp_timeout=1, control=0x0000 still written.
REQ-034 TRDY held 0 for 20 cycles before the 3rd command byte -> status reads repeat, no txdata write until TRDY=1, byte order intact.
REQ-035 Reset asserted during CMD_TX byte 4 -> next cycle outputs at reset values; after release, init sequence restarts from slaveselect=0.
REQ-036 cmd_valid held high through a command -> second command accepted only after the DONE pulse, in the IDLE cycle.
